// File: rtl/recycler_sched.sv
// recycler_sched
//   Sequencing controller for the recycler and the conv MAC bank behind it.
//   Admits one frame at a time from upstream, then holds upstream off while
//   the recycler replays the frame once per filter. Every recycled column
//   window is tagged with (filter, column, weight base address) one cycle
//   after the recycler presents it. Length and protocol errors are sticky.
//
// Ports
//   clk_i, rst_i     clock; asynchronous active-high reset
//   in_valid_i       upstream column beat valid
//   in_last_i        upstream final column of the frame
//   in_ready_o       upstream may transfer (combinational from state)
//   rec_valid_i      recycler output window valid
//   mac_valid_o      tagged window valid to the MAC bank
//   filter_idx_o     filter index of the window
//   col_idx_o        column index of the window within its pass
//   wt_addr_o        filter_idx * FILTER_LEN, base of that filter's taps
//   pass_first_o     window is column 0
//   pass_last_o      window is column FRAME_LEN-1
//   frame_done_o     one-cycle pulse with the final window of the frame
//   frame_cnt_o      completed frames, wraps at 256
//   len_err_o        sticky: frame length did not match FRAME_LEN
//   spur_err_o       sticky: recycler output seen outside the replay phase
module recycler_sched #(
  parameter int FRAME_LEN   = 50,
  parameter int NUM_FILTERS = 8,
  localparam int FILTER_LEN = 3,
  localparam int COL_BW  = ($clog2(FRAME_LEN) > 1) ? $clog2(FRAME_LEN) : 1,
  localparam int FIL_BW  = ($clog2(NUM_FILTERS) > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int ADDR_BW = ($clog2(NUM_FILTERS*FILTER_LEN) > 1) ?
                           $clog2(NUM_FILTERS*FILTER_LEN) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  input  logic               in_last_i,
  output logic               in_ready_o,
  input  logic               rec_valid_i,
  output logic               mac_valid_o,
  output logic [FIL_BW-1:0]  filter_idx_o,
  output logic [COL_BW-1:0]  col_idx_o,
  output logic [ADDR_BW-1:0] wt_addr_o,
  output logic               pass_first_o,
  output logic               pass_last_o,
  output logic               frame_done_o,
  output logic [7:0]         frame_cnt_o,
  output logic               len_err_o,
  output logic               spur_err_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CYCLE = 2'd2;

  localparam logic [COL_BW:0]   BEAT_LEN = (COL_BW+1)'(FRAME_LEN);
  localparam logic [COL_BW-1:0] COL_MAX  = COL_BW'(FRAME_LEN-1);
  localparam logic [FIL_BW-1:0] FIL_MAX  = FIL_BW'(NUM_FILTERS-1);
  localparam logic [ADDR_BW-1:0] TAPS    = ADDR_BW'(FILTER_LEN);

  logic [1:0]         state_q, state_d;
  logic [COL_BW:0]    beat_cnt_q, beat_cnt_d;
  logic [COL_BW-1:0]  col_q, col_d;
  logic [FIL_BW-1:0]  fil_q, fil_d;

  logic               mac_valid_q, mac_valid_d;
  logic [FIL_BW-1:0]  filter_idx_q, filter_idx_d;
  logic [COL_BW-1:0]  col_idx_q, col_idx_d;
  logic [ADDR_BW-1:0] wt_addr_q, wt_addr_d;
  logic               pass_first_q, pass_first_d;
  logic               pass_last_q, pass_last_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               len_err_q, len_err_d;
  logic               spur_err_q, spur_err_d;

  logic               xfer;
  logic [COL_BW:0]    beat_nxt;

  // Unused encoding 2'd3 also deasserts ready so nothing is admitted
  // during the single recovery cycle.
  assign in_ready_o = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign xfer       = in_valid_i & in_ready_o;
  assign beat_nxt   = beat_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    col_d        = col_q;
    fil_d        = fil_q;
    mac_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    filter_idx_d = filter_idx_q;
    col_idx_d    = col_idx_q;
    wt_addr_d    = wt_addr_q;
    pass_first_d = pass_first_q;
    pass_last_d  = pass_last_q;
    frame_cnt_d  = frame_cnt_q;
    len_err_d    = len_err_q;
    spur_err_d   = spur_err_q;

    // Recycler output outside replay is a protocol error and is dropped.
    if (rec_valid_i && state_q != ST_CYCLE) spur_err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        beat_cnt_d = '0;
        col_d      = '0;
        fil_d      = '0;
        if (xfer) begin
          if (in_last_i) begin
            // One-beat frame: always short since FRAME_LEN >= 2.
            len_err_d = 1'b1;
            state_d   = ST_CYCLE;
          end else begin
            beat_cnt_d = (COL_BW+1)'(1);
            state_d    = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          beat_cnt_d = beat_nxt;
          // Leave on last, or truncate at FRAME_LEN beats; a missing or
          // early last is flagged, a late one is never seen (ready drops).
          if (in_last_i || beat_nxt == BEAT_LEN) begin
            state_d = ST_CYCLE;
            col_d   = '0;
            fil_d   = '0;
            if (!(in_last_i && beat_nxt == BEAT_LEN)) len_err_d = 1'b1;
          end
        end
      end

      ST_CYCLE: begin
        if (rec_valid_i) begin
          // Tag from the pre-increment counters.
          mac_valid_d  = 1'b1;
          filter_idx_d = fil_q;
          col_idx_d    = col_q;
          wt_addr_d    = ADDR_BW'(fil_q) * TAPS;
          pass_first_d = (col_q == '0);
          pass_last_d  = (col_q == COL_MAX);
          if (col_q == COL_MAX) begin
            col_d = '0;
            if (fil_q == FIL_MAX) begin
              fil_d        = '0;
              beat_cnt_d   = '0;
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 8'd1;
              state_d      = ST_IDLE;
            end else begin
              fil_d = fil_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      col_q        <= '0;
      fil_q        <= '0;
      mac_valid_q  <= 1'b0;
      filter_idx_q <= '0;
      col_idx_q    <= '0;
      wt_addr_q    <= '0;
      pass_first_q <= 1'b0;
      pass_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      len_err_q    <= 1'b0;
      spur_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      col_q        <= col_d;
      fil_q        <= fil_d;
      mac_valid_q  <= mac_valid_d;
      filter_idx_q <= filter_idx_d;
      col_idx_q    <= col_idx_d;
      wt_addr_q    <= wt_addr_d;
      pass_first_q <= pass_first_d;
      pass_last_q  <= pass_last_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      len_err_q    <= len_err_d;
      spur_err_q   <= spur_err_d;
    end
  end

  assign mac_valid_o  = mac_valid_q;
  assign filter_idx_o = filter_idx_q;
  assign col_idx_o    = col_idx_q;
  assign wt_addr_o    = wt_addr_q;
  assign pass_first_o = pass_first_q;
  assign pass_last_o  = pass_last_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign len_err_o    = len_err_q;
  assign spur_err_o   = spur_err_q;

endmodule

// File: tb/tb_recycler_sched.sv
// Directed bench for recycler_sched (FRAME_LEN=50, NUM_FILTERS=8).
// A table of frame scenarios is run back to back, followed by hand-written
// reset-mid-replay and idle-spurious sequences.
module tb_recycler_sched;
  localparam int FL = 50;
  localparam int NF = 8;
  localparam int COL_BW = 6;
  localparam int FIL_BW = 3;
  localparam int ADDR_BW = 5;
  localparam int TOTAL = FL*NF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, rec_valid = 1'b0;
  logic in_ready, mac_valid, pass_first, pass_last, frame_done, len_err, spur_err;
  logic [FIL_BW-1:0]  filter_idx;
  logic [COL_BW-1:0]  col_idx;
  logic [ADDR_BW-1:0] wt_addr;
  logic [7:0]         frame_cnt;

  always #5 clk = ~clk;

  recycler_sched #(.FRAME_LEN(FL), .NUM_FILTERS(NF)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .rec_valid_i(rec_valid), .mac_valid_o(mac_valid),
    .filter_idx_o(filter_idx), .col_idx_o(col_idx), .wt_addr_o(wt_addr),
    .pass_first_o(pass_first), .pass_last_o(pass_last),
    .frame_done_o(frame_done), .frame_cnt_o(frame_cnt),
    .len_err_o(len_err), .spur_err_o(spur_err)
  );

  int   n_assert = 0;
  int   n_fail = 0;
  logic exp_len = 1'b0;
  logic exp_spur = 1'b0;
  int   exp_fcnt = 0;

  typedef struct {
    string name;
    int    nbeats;     // beats driven with in_valid
    int    last_beat;  // beat carrying in_last (0 = none)
    bit    spur_load;  // pulse rec_valid on beat 10 while loading
    bit    gap;        // random idle cycles between recycler beats
    bit    len_err;    // frame is expected to raise len_err
    int    cyc_beat;   // beat after which ready drops (CYCLE entered)
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "/outs"}, {mac_valid, filter_idx, col_idx, wt_addr, pass_first,
                        pass_last, frame_done, frame_cnt, len_err, spur_err}, 64'd0);
    chk({nm, "/ready"}, in_ready, 1);
  endtask

  task automatic load(input vec_t v);
    for (int b = 1; b <= v.nbeats; b++) begin
      in_valid  = 1'b1;
      in_last   = (b == v.last_beat);
      rec_valid = v.spur_load && (b == 10);
      @(posedge clk); #1;
      chk({v.name, "/ready"}, in_ready, (b < v.cyc_beat));
      chk({v.name, "/mac_quiet"}, mac_valid, 0);
      if (rec_valid) begin
        exp_spur = 1'b1;
        chk({v.name, "/spur_load"}, spur_err, 1);
      end
    end
    rec_valid = 1'b0;
    if (v.len_err) exp_len = 1'b1;
    chk({v.name, "/len_err"}, len_err, exp_len);
  endtask

  // Drive nstop recycler beats with upstream pushing valid+last throughout.
  task automatic recycle(input string nm, input int nstop, input bit gap);
    int k = 0;
    int cyc = 0;
    logic rv;
    logic [17:0] e;
    while (k < nstop && cyc < 4*TOTAL) begin
      chk({nm, "/ready_low"}, in_ready, 0);
      rv = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = 1'b1; in_last = 1'b1; rec_valid = rv;
      @(posedge clk); #1;
      cyc++;
      if (rv) begin
        e = {1'b1, FIL_BW'(k / FL), COL_BW'(k % FL), ADDR_BW'((k / FL) * 3),
             (k % FL) == 0, (k % FL) == FL-1, k == TOTAL-1};
        if (k == TOTAL-1) exp_fcnt++;
        chk({nm, "/tag"}, {mac_valid, filter_idx, col_idx, wt_addr, pass_first,
                           pass_last, frame_done}, e);
        chk({nm, "/frame_cnt"}, frame_cnt, exp_fcnt[7:0]);
        k++;
      end else begin
        chk({nm, "/gap_quiet"}, {mac_valid, frame_done}, 0);
      end
    end
    in_valid = 1'b0; in_last = 1'b0; rec_valid = 1'b0;
    if (k < nstop) chk({nm, "/timeout"}, k, nstop);
  endtask

  initial begin
    vecs[0] = '{"nominal",    50, 50, 1'b0, 1'b0, 1'b0, 50};
    vecs[1] = '{"backtoback", 50, 50, 1'b0, 1'b0, 1'b0, 50};
    vecs[2] = '{"gapped",     50, 50, 1'b0, 1'b1, 1'b0, 50};
    vecs[3] = '{"spur_load",  50, 50, 1'b1, 1'b0, 1'b0, 50};
    vecs[4] = '{"short30",    30, 30, 1'b0, 1'b0, 1'b1, 30};
    vecs[5] = '{"no_last",    50,  0, 1'b0, 1'b0, 1'b1, 50};
    vecs[6] = '{"single",      1,  1, 1'b0, 1'b0, 1'b1,  1};

    rst = 1'b1;
    #12;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      load(vecs[i]);
      recycle(vecs[i].name, TOTAL, vecs[i].gap);
      chk({vecs[i].name, "/ready_back"}, in_ready, 1);
      chk({vecs[i].name, "/len_sticky"}, len_err, exp_len);
      chk({vecs[i].name, "/spur_sticky"}, spur_err, exp_spur);
    end
    chk("table/frame_cnt", frame_cnt, 8'd7);

    // Reset asserted between edges after 123 windows of a replay.
    load(vecs[0]);
    recycle("partial", 123, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    exp_len = 1'b0; exp_spur = 1'b0; exp_fcnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Recycler output while idle: flagged, never forwarded.
    rec_valid = 1'b1;
    @(posedge clk); #1;
    rec_valid = 1'b0;
    exp_spur = 1'b1;
    chk("idle_spur/flag", spur_err, 1);
    chk("idle_spur/mac", mac_valid, 0);

    load(vecs[0]);
    recycle("after_reset", TOTAL, 1'b0);
    chk("after_reset/frame_cnt", frame_cnt, 8'd1);
    chk("after_reset/len", len_err, 0);
    chk("after_reset/spur", spur_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/recycler_sched.md
# recycler_sched

Sequencing controller for the recycler and the conv MAC bank that follows it. Admits exactly one frame at a time from upstream and blocks input while the recycler replays that frame once per filter. Counts recycled column windows and tags each one with filter index, column index and weight-memory base address. Flags length and protocol errors and pulses a done strobe when all filters have consumed the frame.

## Interface
Parameters:
- FRAME_LEN, 50: columns per frame; legal values are 2 or more.
- NUM_FILTERS, 8: filters per frame; legal values are 1 or more.
- FILTER_LEN: localparam fixed at 3; taps per filter.
- Derived widths:
  - COL_BW = max(1, $clog2(FRAME_LEN))
  - FIL_BW = max(1, $clog2(NUM_FILTERS))
  - ADDR_BW = max(1, $clog2(NUM_FILTERS*FILTER_LEN))

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- rst_i  in  1  reset; asynchronous, active-high.
- in_valid_i  in  1  upstream column beat valid (parallel to the recycler's data input).
- in_last_i  in  1  final column of the frame.
- in_ready_o  out  1  upstream may transfer; gates the recycler's valid/last inputs.
- rec_valid_i  in  1  recycler output window valid.
- mac_valid_o  out  1  tagged window valid to the MAC bank.
- filter_idx_o  out  FIL_BW  filter for this window.
- col_idx_o  out  COL_BW  column position within the pass.
- wt_addr_o  out  ADDR_BW  filter_idx*FILTER_LEN, the base of that filter's taps.
- pass_first_o  out  1  col_idx_o==0.
- pass_last_o  out  1  col_idx_o==FRAME_LEN-1.
- frame_done_o  out  1  one-cycle pulse on the final window of the frame.
- frame_cnt_o  out  8  completed frames; wraps from 255 to 0.
- len_err_o  out  1  sticky: in_last_i did not arrive on beat FRAME_LEN.
- spur_err_o  out  1  sticky: rec_valid_i seen outside CYCLE.

## Operation
- A transfer is in_valid_i & in_ready_o. in_ready_o is combinational: 1 in IDLE and LOAD, 0 in CYCLE.
- Internal counters:
  - beat_cnt (COL_BW+1 bits)
  - col (COL_BW bits)
  - fil (FIL_BW bits)
- IDLE: beat_cnt=0.
  - Transfer without last: go to LOAD with beat_cnt=1.
  - Transfer with last: set len_err_o, go to CYCLE.
- LOAD: each transfer increments beat_cnt.
  - Transfer with last: go to CYCLE. If beat_cnt+1 != FRAME_LEN, set len_err_o. col=0, fil=0.
  - Beat FRAME_LEN arrives without last: set len_err_o and go to CYCLE anyway. The frame is truncated at FRAME_LEN; the late last is later ignored, since ready is low.
- CYCLE: each rec_valid_i beat captures the (fil, col) tag into the output registers, then advances the counters:
  - col increments; at FRAME_LEN-1 it wraps to 0 and fil increments.
  - When the beat at col==FRAME_LEN-1 and fil==NUM_FILTERS-1 is captured, go to IDLE and increment frame_cnt_o.
- rec_valid_i in IDLE or LOAD: set spur_err_o; no tag or counter change; mac_valid_o stays 0.
- in_valid_i during CYCLE is held off (ready=0) and is not an error.
- Error flags clear only on rst_i.
- Reset values, asserted asynchronously:
  - Go to IDLE; all counters 0.
  - mac_valid_o, pass_first_o, pass_last_o, frame_done_o, len_err_o, spur_err_o all 0.
  - filter_idx_o, col_idx_o, wt_addr_o, frame_cnt_o all 0.
  - Reset mid-frame discards the frame with no done pulse.
- States are encoded in 2 bits; the unused encoding recovers to IDLE on the next clock.

## Timing
- Tag outputs (mac_valid_o, idx, addr, first/last, frame_done_o) are registered: 1-cycle latency from rec_valid_i in CYCLE.
- mac_valid_o is 0 in any cycle not preceded by an accepted rec_valid_i.
- frame_done_o is high in the same cycle as the final mac_valid_o, which also has pass_last_o=1 and filter_idx_o=NUM_FILTERS-1.
- frame_cnt_o updates in that same cycle.
- Back-to-back frames: in_ready_o returns to 1 in the cycle after the final rec_valid_i. The next frame's first beat may transfer that cycle while the done pulse is on the outputs.
- len_err_o and spur_err_o rise in the cycle after the offending edge.
- wt_addr_o is computed from the counter value being captured, never the post-increment value.
- No gaps are required between rec_valid_i beats; one beat per cycle is sustained.

## Test plan
- Nominal frame (FRAME_LEN=50, NUM_FILTERS=8): 50 transfers with last on beat 50, then 400 consecutive rec_valid_i.
  - Expect 400 mac_valid_o beats.
  - Tags run (0,0)…(0,49),(1,0)…(7,49).
  - wt_addr_o steps 0,3,…,21.
  - Exactly one frame_done_o, on beat 400; frame_cnt_o=1; no errors.
- Backpressure: in_valid_i held high throughout CYCLE.
  - in_ready_o=0 for the whole CYCLE phase.
  - The second frame transfers starting the cycle after the last rec_valid_i.
  - frame_cnt_o reaches 2 after the second cycle phase.
- Short/long frame:
  - last on beat 30: len_err_o=1 and the block enters CYCLE.
  - Separate run, no last by beat 50: len_err_o=1, CYCLE entered after beat 50.
- Spurious recycler output: rec_valid_i pulsed in IDLE and in LOAD.
  - spur_err_o=1, mac_valid_o stays 0.
  - Later frame tags still start at (0,0).
- Gapped recycling: rec_valid_i with random idle cycles.
  - Tags and the done pulse are identical to the nominal run, each 1 cycle after its beat.
- Reset mid-CYCLE: rst_i asserted asynchronously after 123 windows.
  - All outputs go to 0 immediately and state returns to IDLE.
  - The next full frame completes normally with frame_cnt_o=1.
